deparser_layer_param: RTL and testbench

DEPARSER_LAYER_PARAM -- requirements
Module: deparser_layer_param

---
 rtl/deparser_layer_param.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_deparser_layer_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deparser_layer_param.sv
// Header deparser: a type field selects a rule, key bytes are copied from meta
// into head, then head and meta are left-shifted. Two-stage pipeline with a
// 32-bit config port for the rule table.
module deparser_layer_param #(
  parameter int unsigned HEAD_WIDTH = 512,
  parameter int unsigned META_WIDTH = 256,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned TYPE_WIDTH = 16,
  parameter int unsigned KEY_NUM    = 4,
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned RULE_NUM   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_rule_wren,
  input  logic                            i_rule_rden,
  input  logic [31:0]                     i_rule_addr,
  input  logic [31:0]                     i_rule_wdata,
  output logic                            o_rule_rdata_valid,
  output logic [31:0]                     o_rule_rdata,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
  output logic                            o_miss
);

  localparam int unsigned HW = HEAD_WIDTH + TAG_WIDTH;
  localparam int unsigned MW = META_WIDTH + TAG_WIDTH;

  // ---------------- rule table ----------------
  logic [RULE_NUM-1:0]                         rule_valid_q;
  logic [RULE_NUM-1:0][TYPE_WIDTH-1:0]         rule_type_q;
  logic [RULE_NUM-1:0][TYPE_WIDTH-1:0]         rule_mask_q;
  logic [RULE_NUM-1:0][7:0]                    rule_hshift_q;
  logic [RULE_NUM-1:0][7:0]                    rule_mshift_q;
  logic [RULE_NUM-1:0][KEY_NUM-1:0]            key_en_q;
  logic [RULE_NUM-1:0][KEY_NUM-1:0][7:0]       key_src_q;
  logic [RULE_NUM-1:0][KEY_NUM-1:0][7:0]       key_dst_q;
  logic [7:0]                                  type_off_q;

  logic [7:0]  cfg_idx;
  logic [7:0]  cfg_word;
  logic        cfg_hi_zero;
  logic [31:0] rd_val;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;
  logic        unused_wdata;

  assign cfg_idx      = i_rule_addr[15:8];
  assign cfg_word     = i_rule_addr[7:0];
  assign cfg_hi_zero  = (i_rule_addr[31:16] == 16'h0000);
  assign unused_wdata = ^i_rule_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rule_valid_q  <= '0;
      rule_type_q   <= '0;
      rule_mask_q   <= '0;
      rule_hshift_q <= '0;
      rule_mshift_q <= '0;
      key_en_q      <= '0;
      key_src_q     <= '0;
      key_dst_q     <= '0;
      type_off_q    <= '0;
    end else if (i_rule_wren && cfg_hi_zero) begin
      if (cfg_idx == 8'hFF && cfg_word == 8'h00) type_off_q <= i_rule_wdata[7:0];
      for (int unsigned r = 0; r < RULE_NUM; r++) begin
        if (32'(cfg_idx) == r) begin
          case (cfg_word)
            8'd0: begin
              rule_valid_q[r] <= i_rule_wdata[31];
              rule_type_q[r]  <= i_rule_wdata[TYPE_WIDTH-1:0];
            end
            8'd1: rule_mask_q[r] <= i_rule_wdata[TYPE_WIDTH-1:0];
            8'd2: begin
              rule_mshift_q[r] <= i_rule_wdata[15:8];
              rule_hshift_q[r] <= i_rule_wdata[7:0];
            end
            default: ;
          endcase
          for (int unsigned k = 0; k < KEY_NUM; k++) begin
            if (32'(cfg_word) == k + 3) begin
              key_en_q[r][k]  <= i_rule_wdata[31];
              key_src_q[r][k] <= i_rule_wdata[23:16];
              key_dst_q[r][k] <= i_rule_wdata[7:0];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (cfg_hi_zero) begin
      if (cfg_idx == 8'hFF && cfg_word == 8'h00) rd_val[7:0] = type_off_q;
      for (int unsigned r = 0; r < RULE_NUM; r++) begin
        if (32'(cfg_idx) == r) begin
          case (cfg_word)
            8'd0: begin
              rd_val[31]             = rule_valid_q[r];
              rd_val[TYPE_WIDTH-1:0] = rule_type_q[r];
            end
            8'd1: rd_val[TYPE_WIDTH-1:0] = rule_mask_q[r];
            8'd2: rd_val[15:0] = {rule_mshift_q[r], rule_hshift_q[r]};
            default: ;
          endcase
          for (int unsigned k = 0; k < KEY_NUM; k++) begin
            if (32'(cfg_word) == k + 3)
              rd_val = {key_en_q[r][k], 7'd0, key_src_q[r][k], 8'd0, key_dst_q[r][k]};
          end
        end
      end
    end
  end

  // Read data is sampled before any same-cycle write lands, so RW collisions see the old value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= i_rule_rden;
      if (i_rule_rden) rd_data_q <= rd_val;
    end
  end

  assign o_rule_rdata_valid = rd_valid_q;
  assign o_rule_rdata       = rd_data_q;

  // ---------------- field helpers (byte 0 = MSB of data) ----------------
  function automatic logic [TYPE_WIDTH-1:0] get_type(input logic [HEAD_WIDTH-1:0] d,
                                                     input logic [7:0] off);
    logic [HEAD_WIDTH-1:0] t;
    t = d << {off, 3'b000};
    return t[HEAD_WIDTH-1 -: TYPE_WIDTH];
  endfunction

  function automatic logic [KEY_WIDTH-1:0] get_key(input logic [META_WIDTH-1:0] d,
                                                   input logic [7:0] off);
    logic [META_WIDTH-1:0] t;
    t = d << {off, 3'b000};
    return t[META_WIDTH-1 -: KEY_WIDTH];
  endfunction

  function automatic logic [HEAD_WIDTH-1:0] put_key(input logic [HEAD_WIDTH-1:0] d,
                                                    input logic [7:0] off,
                                                    input logic [KEY_WIDTH-1:0] f);
    logic [HEAD_WIDTH-1:0] m;
    logic [HEAD_WIDTH-1:0] v;
    m = '0;
    v = '0;
    m[HEAD_WIDTH-1 -: KEY_WIDTH] = '1;
    v[HEAD_WIDTH-1 -: KEY_WIDTH] = f;
    m = m >> {off, 3'b000};
    v = v >> {off, 3'b000};
    return (d & ~m) | v;
  endfunction

  // ---------------- pipeline control ----------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_en;
  logic s2_en;

  assign s2_en   = !s2_valid_q || i_ready;
  assign s1_en   = !s1_valid_q || s2_en;
  assign o_ready = s1_en;

  // ---------------- stage 1: type extract + rule match ----------------
  logic [TYPE_WIDTH-1:0]         type_fld;
  logic                          hit_d;
  logic [KEY_NUM-1:0]            en_d;
  logic [KEY_NUM-1:0][7:0]       src_d;
  logic [KEY_NUM-1:0][7:0]       dst_d;
  logic [7:0]                    hs_d;
  logic [7:0]                    ms_d;

  assign type_fld = get_type(i_head[HW-1:TAG_WIDTH], type_off_q);

  always_comb begin
    hit_d = 1'b0;
    en_d  = '0;
    src_d = '0;
    dst_d = '0;
    hs_d  = '0;
    ms_d  = '0;
    for (int unsigned r = 0; r < RULE_NUM; r++) begin
      if (!hit_d && rule_valid_q[r] &&
          ((type_fld & rule_mask_q[r]) == (rule_type_q[r] & rule_mask_q[r]))) begin
        hit_d = 1'b1;
        en_d  = key_en_q[r];
        src_d = key_src_q[r];
        dst_d = key_dst_q[r];
        hs_d  = rule_hshift_q[r];
        ms_d  = rule_mshift_q[r];
      end
    end
  end

  // The matched rule's actions are snapshotted so later config writes don't touch captured beats.
  logic [HW-1:0]           s1_head_q;
  logic [MW-1:0]           s1_meta_q;
  logic                    s1_hit_q;
  logic [KEY_NUM-1:0]      s1_en_q;
  logic [KEY_NUM-1:0][7:0] s1_src_q;
  logic [KEY_NUM-1:0][7:0] s1_dst_q;
  logic [7:0]              s1_hs_q;
  logic [7:0]              s1_ms_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_head_q  <= '0;
      s1_meta_q  <= '0;
      s1_hit_q   <= 1'b0;
      s1_en_q    <= '0;
      s1_src_q   <= '0;
      s1_dst_q   <= '0;
      s1_hs_q    <= '0;
      s1_ms_q    <= '0;
    end else if (s1_en) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_head_q <= i_head;
        s1_meta_q <= i_meta;
        s1_hit_q  <= hit_d;
        s1_en_q   <= en_d;
        s1_src_q  <= src_d;
        s1_dst_q  <= dst_d;
        s1_hs_q   <= hs_d;
        s1_ms_q   <= ms_d;
      end
    end
  end

  // ---------------- stage 2: key replacement + shifts ----------------
  logic [HEAD_WIDTH-1:0] hd_d;
  logic [META_WIDTH-1:0] md_d;

  always_comb begin
    hd_d = s1_head_q[HW-1:TAG_WIDTH];
    md_d = s1_meta_q[MW-1:TAG_WIDTH];
    if (s1_hit_q) begin
      for (int unsigned k = 0; k < KEY_NUM; k++) begin
        if (s1_en_q[k]) hd_d = put_key(hd_d, s1_dst_q[k], get_key(md_d, s1_src_q[k]));
      end
      hd_d = hd_d << {s1_hs_q, 3'b000};
      md_d = md_d << {s1_ms_q, 3'b000};
    end
  end

  logic [HW-1:0] out_head_q;
  logic [MW-1:0] out_meta_q;
  logic          out_miss_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      out_head_q <= '0;
      out_meta_q <= '0;
      out_miss_q <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      out_miss_q <= s1_valid_q && !s1_hit_q;
      if (s1_valid_q) begin
        out_head_q <= {hd_d, s1_head_q[TAG_WIDTH-1:0]};
        out_meta_q <= {md_d, s1_meta_q[TAG_WIDTH-1:0]};
      end
    end
  end

  assign o_valid = s2_valid_q;
  assign o_head  = out_head_q;
  assign o_meta  = out_meta_q;
  assign o_miss  = out_miss_q;

endmodule

// File: tb/tb_deparser_layer_param.sv
// Directed bench for deparser_layer_param: vector table of single beats plus
// config-port, streaming/stall and mid-operation reset sequences.
module tb_deparser_layer_param;
  localparam int HW = 512;
  localparam int MW = 256;
  localparam int TW = 8;
  localparam int HB = HW / 8;
  localparam int MB = MW / 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rule_wren, rule_rden;
  logic [31:0]    rule_addr, rule_wdata;
  logic           rule_rdata_valid;
  logic [31:0]    rule_rdata;
  logic           in_valid, out_ready_dut, out_valid, in_ready, miss;
  logic [HW+TW-1:0] in_head, out_head;
  logic [MW+TW-1:0] in_meta, out_meta;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deparser_layer_param #(
    .HEAD_WIDTH(HW), .META_WIDTH(MW), .TAG_WIDTH(TW),
    .TYPE_WIDTH(16), .KEY_NUM(4), .KEY_WIDTH(16), .RULE_NUM(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rule_wren(rule_wren), .i_rule_rden(rule_rden),
    .i_rule_addr(rule_addr), .i_rule_wdata(rule_wdata),
    .o_rule_rdata_valid(rule_rdata_valid), .o_rule_rdata(rule_rdata),
    .i_valid(in_valid), .o_ready(out_ready_dut), .i_head(in_head), .i_meta(in_meta),
    .o_valid(out_valid), .i_ready(in_ready), .o_head(out_head), .o_meta(out_meta),
    .o_miss(miss)
  );

  task automatic check(input string nm, input logic [599:0] act, input logic [599:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] sh(input logic [HW-1:0] v, input int b, input logic [7:0] x);
    v[HW-1-8*b -: 8] = x;
    return v;
  endfunction
  function automatic logic [MW-1:0] sm(input logic [MW-1:0] v, input int b, input logic [7:0] x);
    v[MW-1-8*b -: 8] = x;
    return v;
  endfunction
  function automatic logic [7:0] gm(input logic [MW-1:0] v, input int b);
    return v[MW-1-8*b -: 8];
  endfunction
  function automatic logic [HW-1:0] pat_h(input logic [7:0] seed);
    logic [HW-1:0] v;
    for (int b = 0; b < HB; b++) v[HW-1-8*b -: 8] = 8'(seed + 3 * b);
    return v;
  endfunction
  function automatic logic [MW-1:0] pat_m(input logic [7:0] seed);
    logic [MW-1:0] v;
    for (int b = 0; b < MB; b++) v[MW-1-8*b -: 8] = 8'(seed + 3 * b);
    return v;
  endfunction
  function automatic logic [HW-1:0] shl_h(input logic [HW-1:0] v, input int n);
    logic [HW-1:0] r = '0;
    for (int b = 0; b + n < HB; b++) r[HW-1-8*b -: 8] = v[HW-1-8*(b+n) -: 8];
    return r;
  endfunction
  function automatic logic [MW-1:0] shl_m(input logic [MW-1:0] v, input int n);
    logic [MW-1:0] r = '0;
    for (int b = 0; b + n < MB; b++) r[MW-1-8*b -: 8] = v[MW-1-8*(b+n) -: 8];
    return r;
  endfunction

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rule_wren = 1'b1; rule_addr = a; rule_wdata = d;
    @(negedge clk);
    rule_wren = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    rule_rden = 1'b1; rule_addr = a;
    @(posedge clk); #1;
    check({nm, " rvalid"}, 600'(rule_rdata_valid), 600'(1'b1));
    check({nm, " rdata"}, 600'(rule_rdata), 600'(exp));
    @(negedge clk);
    rule_rden = 1'b0;
    @(posedge clk); #1;
    check({nm, " rvalid drop"}, 600'(rule_rdata_valid), 600'(1'b0));
  endtask

  typedef struct {
    int             nwr;
    logic [3:0][31:0] wa;
    logic [3:0][31:0] wd;
    logic [HW-1:0]  hd;
    logic [MW-1:0]  md;
    logic [TW-1:0]  tag;
    logic [HW-1:0]  ehd;
    logic [MW-1:0]  emd;
    logic           emiss;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [HW-1:0] h, hx;
    logic [MW-1:0] m;
    logic [HW-1:0] bh[10];
    logic [HW-1:0] beh[10];
    logic [HW+TW-1:0] held;
    int lat, sent, recv, cyc, extra;
    logic stall_prev, in_fire, out_fire;

    rst_n = 1'b0; rule_wren = 1'b0; rule_rden = 1'b0; rule_addr = '0; rule_wdata = '0;
    in_valid = 1'b0; in_ready = 1'b1; in_head = '0; in_meta = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("reset o_ready", 600'(out_ready_dut), 600'(1'b1));
    check("reset o_valid", 600'(out_valid), 600'(1'b0));
    check("reset o_miss", 600'(miss), 600'(1'b0));
    check("reset o_head", 600'(out_head), 600'(0));
    check("reset o_meta", 600'(out_meta), 600'(0));
    check("reset rdata", 600'({rule_rdata_valid, rule_rdata}), 600'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // ---- config port ----
    cfg_read(32'h0000_0000, 32'h0, "rule0 w0 after reset");
    cfg_write(32'h0000_0201, 32'h0000_FF00);
    cfg_read(32'h0000_0201, 32'h0000_FF00, "rule2 w1");
    cfg_read(32'h0000_0910, 32'h0, "unimpl read");
    cfg_write(32'h0000_0910, 32'hDEAD_BEEF);
    cfg_read(32'h0000_0910, 32'h0, "unimpl after write");
    @(negedge clk);
    rule_rden = 1'b1; rule_wren = 1'b1; rule_addr = 32'h0000_0201; rule_wdata = 32'h0000_1234;
    @(posedge clk); #1;
    check("rw collide old", 600'(rule_rdata), 600'(32'h0000_FF00));
    @(negedge clk);
    rule_rden = 1'b0; rule_wren = 1'b0;
    cfg_read(32'h0000_0201, 32'h0000_1234, "rw collide new");

    // ---- base rule setup ----
    cfg_write(32'h0000_FF00, 32'd12);
    cfg_read(32'h0000_FF00, 32'd12, "type offset");
    cfg_write(32'h0000_0000, 32'h8000_0800);
    cfg_write(32'h0000_0001, 32'h0000_FFFF);
    cfg_write(32'h0000_0003, 32'h8000_000E);
    cfg_read(32'h0000_0003, 32'h8000_000E, "rule0 key0");

    // ---- vector table ----
    h = sh(sh(pat_h(8'h10), 12, 8'h08), 13, 8'h00);
    m = sm(sm(pat_m(8'h40), 0, 8'hAB), 1, 8'hCD);
    for (int i = 0; i < 11; i++) begin
      vt[i].nwr = 0; vt[i].wa = '0; vt[i].wd = '0;
      vt[i].hd = h; vt[i].md = m; vt[i].tag = 8'(8'h50 + i);
      vt[i].ehd = sh(sh(h, 14, 8'hAB), 15, 8'hCD); vt[i].emd = m; vt[i].emiss = 1'b0;
    end
    // v1: unmatched type passes through
    vt[1].hd = sh(sh(h, 12, 8'h86), 13, 8'hDD); vt[1].ehd = vt[1].hd; vt[1].emiss = 1'b1;
    // v2: key at last byte, second byte dropped
    vt[2].nwr = 1; vt[2].wa[0] = 32'h0003; vt[2].wd[0] = 32'h8000_003F;
    vt[2].ehd = sh(h, 63, 8'hAB);
    // v3: source runs off end of meta -> zero byte
    vt[3].nwr = 1; vt[3].wa[0] = 32'h0004; vt[3].wd[0] = 32'h801F_0014;
    vt[3].ehd = sh(sh(sh(h, 63, 8'hAB), 20, gm(m, 31)), 21, 8'h00);
    // v4: key1 overlaps key0 and wins
    vt[4].nwr = 1; vt[4].wa[0] = 32'h0004; vt[4].wd[0] = 32'h801F_003E;
    vt[4].ehd = sh(sh(h, 62, gm(m, 31)), 63, 8'h00);
    // v5: headShift 14, metaShift 2
    vt[5].nwr = 3;
    vt[5].wa[0] = 32'h0003; vt[5].wd[0] = 32'h8000_000E;
    vt[5].wa[1] = 32'h0004; vt[5].wd[1] = 32'h0;
    vt[5].wa[2] = 32'h0002; vt[5].wd[2] = 32'h0000_020E;
    vt[5].ehd = shl_h(sh(sh(h, 14, 8'hAB), 15, 8'hCD), 14); vt[5].emd = shl_m(m, 2);
    // v6: shifts equal to the vector widths clear the data
    vt[6].nwr = 1; vt[6].wa[0] = 32'h0002; vt[6].wd[0] = 32'h0000_2040;
    vt[6].ehd = '0; vt[6].emd = '0;
    // v7: mask 0xFF00 ignores the low type byte
    vt[7].nwr = 2;
    vt[7].wa[0] = 32'h0002; vt[7].wd[0] = 32'h0;
    vt[7].wa[1] = 32'h0001; vt[7].wd[1] = 32'h0000_FF00;
    hx = sh(h, 13, 8'h77); vt[7].hd = hx; vt[7].ehd = sh(sh(hx, 14, 8'hAB), 15, 8'hCD);
    // v8: type offset 63, low type byte falls off the end; rule1 also matches but rule0 wins
    vt[8].nwr = 4;
    vt[8].wa[0] = 32'hFF00; vt[8].wd[0] = 32'd63;
    vt[8].wa[1] = 32'h0100; vt[8].wd[1] = 32'h8000_0000;
    vt[8].wa[2] = 32'h0103; vt[8].wd[2] = 32'h8002_0014;
    vt[8].wa[3] = 32'h0300; vt[8].wd[3] = 32'h8000_0000;
    hx = sh(sh(sh(h, 12, 8'h12), 13, 8'h34), 63, 8'h08);
    vt[8].hd = hx; vt[8].ehd = sh(sh(hx, 14, 8'hAB), 15, 8'hCD);
    // v9: rules 1 and 3 both match (mask 0); rule1 applies
    vt[9].nwr = 3;
    vt[9].wa[0] = 32'h0303; vt[9].wd[0] = 32'h8004_0014;
    vt[9].wa[1] = 32'hFF00; vt[9].wd[1] = 32'd12;
    vt[9].wa[2] = 32'h0001; vt[9].wd[2] = 32'h0000_FFFF;
    hx = sh(sh(h, 12, 8'h12), 13, 8'h34);
    vt[9].hd = hx; vt[9].ehd = sh(sh(hx, 20, gm(m, 2)), 21, gm(m, 3));
    // v10: exact match on rule0 beats the catch-all rules

    for (int i = 0; i < 11; i++) begin
      for (int w = 0; w < vt[i].nwr; w++) cfg_write(vt[i].wa[w], vt[i].wd[w]);
      @(negedge clk);
      in_valid = 1'b1; in_ready = 1'b1;
      in_head = {vt[i].hd, vt[i].tag}; in_meta = {vt[i].md, ~vt[i].tag};
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!out_valid && lat < 8);
      check($sformatf("vec%0d latency", i), 600'(lat), 600'(2));
      check($sformatf("vec%0d head", i), 600'(out_head), 600'({vt[i].ehd, vt[i].tag}));
      check($sformatf("vec%0d meta", i), 600'(out_meta), 600'({vt[i].emd, ~vt[i].tag}));
      check($sformatf("vec%0d miss", i), 600'(miss), 600'(vt[i].emiss));
      @(negedge clk);
    end

    // ---- stream of 10 with a 3-cycle output stall ----
    for (int i = 0; i < 10; i++) begin
      bh[i] = sh(h, 30, 8'(i));
      beh[i] = sh(sh(bh[i], 14, 8'hAB), 15, 8'hCD);
    end
    sent = 0; recv = 0; cyc = 0; stall_prev = 1'b0; held = '0;
    while (recv < 10 && cyc < 80) begin
      @(negedge clk);
      in_ready = !(cyc >= 5 && cyc < 8);
      if (sent < 10) begin
        in_valid = 1'b1; in_head = {bh[sent], 8'(sent)}; in_meta = {m, 8'(sent)};
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        check($sformatf("stall valid c%0d", cyc), 600'(out_valid), 600'(1'b1));
        check($sformatf("stall head c%0d", cyc), 600'(out_head), 600'(held));
      end
      stall_prev = out_valid && !in_ready;
      if (stall_prev) held = out_head;
      in_fire = in_valid && out_ready_dut;
      out_fire = out_valid && in_ready;
      if (out_fire) begin
        check($sformatf("stream head %0d", recv), 600'(out_head), 600'({beh[recv], 8'(recv)}));
        check($sformatf("stream miss %0d", recv), 600'(miss), 600'(1'b0));
        recv++;
      end
      if (in_fire) sent++;
      @(posedge clk);
      cyc++;
    end
    check("stream received", 600'(recv), 600'(10));
    @(negedge clk);
    in_valid = 1'b0; in_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("stream no extra", 600'(extra), 600'(0));

    // ---- reset with beats in flight ----
    @(negedge clk);
    in_valid = 1'b1; in_head = {bh[0], 8'hEE}; in_meta = {m, 8'hEE};
    @(negedge clk);
    in_head = {bh[1], 8'hEF};
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset o_valid", 600'(out_valid), 600'(1'b0));
    check("midreset o_ready", 600'(out_ready_dut), 600'(1'b1));
    check("midreset o_head", 600'(out_head), 600'(0));
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check("post-reset emitted", 600'(extra), 600'(0));
    cfg_read(32'h0000_0000, 32'h0, "rule0 w0 after midreset");
    cfg_read(32'h0000_FF00, 32'h0, "type offset after midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
